fir_ctrl: RTL and testbench
===========================

Name: fir_ctrl

Overview:
- Control/sequencing engine for the 11-tap FIR datapath.
- Owns block-level status (ap_start/ap_done/ap_idle) and the per-sample schedule: accepts one AXI-Stream input sample, writes it into the 11-entry circular data BRAM, and walks 11 tap/data address pairs into the MAC datapath.
- Presents the result on AXI-Stream output.
- Sits between the AXI-lite register file, the tap/data bram11 instances and the multiply-accumulate datapath.

Parameters:
- pADDR_WIDTH, 12, BRAM byte-address width.
- pDATA_WIDTH, 32, sample/coef width; used only for cfg_len width.
- Tape_Num, 11, number of taps and data-buffer depth.

Ports:
- axis_clk  in  1  single clock; all logic rising-edge.
- axis_rst_n  in  1  reset; asynchronous, active-low.
- cfg_start  in  1  one-cycle pulse: AXI-lite write of 1 to bit0 @0x00.
- cfg_len  in  32  data_length register (0x10); sampled at start.
- sts_rd  in  1  one-cycle pulse: AXI-lite read handshake of 0x00.
- ap_start  out  1  status bit0.
- ap_done  out  1  status bit1.
- ap_idle  out  1  status bit2.
- ss_tvalid  in  1  input stream valid.
- ss_tlast  in  1  input stream last.
- ss_tready  out  1  input stream ready.
- sm_tready  in  1  output stream ready.
- sm_tvalid  out  1  output stream valid.
- sm_tlast  out  1  output stream last.
- data_WE  out  4  data BRAM byte write enables; 4'hF or 0.
- data_EN  out  1  data BRAM enable.
- data_A  out  pADDR_WIDTH  data BRAM byte address = index<<2.
- tap_EN  out  1  tap BRAM enable (engine side).
- tap_A  out  pADDR_WIDTH  tap BRAM byte address = k<<2.
- data_sel  out  1  data_Di mux: 0 = zero, 1 = ss_tdata.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate tap_Do*data_Do this cycle.
- tap_busy  out  1  engine owns tap BRAM; register file must stall coefficient access.
- tlast_err  out  1  sticky ss_tlast/length mismatch.

Behaviour:
- Reset values: ap_idle=1; all other outputs 0. Internal: wptr=0, cnt=0, state IDLE. Reset mid-operation aborts immediately; BRAM contents are untouched (CLEAR rewrites them on the next start).
- BRAM read latency is 1 cycle: the address presented in cycle n has its data valid in cycle n+1.
- States: IDLE, CLEAR, IN, MAC, DRAIN, OUT, DONE.
- IDLE:
  - cfg_start sets ap_start=1, latches len=cfg_len, cnt=0, wptr=0 and moves to CLEAR.
  - Next cycle: ap_start=0, ap_idle=0, ap_done=0.
- CLEAR: 11 cycles writing zero to data index 0..10 (data_sel=0, data_WE=F), then IN. If len==0, go to DONE instead.
- IN:
  - ss_tready=1. On ss_tvalid, write ss_tdata to index wptr (data_sel=1), assert mac_clr, and go to MAC with k=0.
  - ss_tready is 0 in every other state.
- MAC:
  - 11 cycles, k=0..10: tap_A=k<<2, data_A=((wptr-k) mod 11)<<2, both EN=1.
  - mac_en is k-valid delayed by 1, so it spans MAC cycles 1..10 plus DRAIN.
- DRAIN: 1 cycle, then OUT.
- OUT:
  - sm_tvalid=1 and held stable until sm_tready; sm_tlast=(cnt==len-1).
  - On handshake: cnt++, wptr=(wptr==10)?0:wptr+1. Go to DONE if cnt+1==len, else IN.
- Minimum per-sample period: 1 (IN) + 11 + 1 + 1 = 14 cycles with sm_tready held at 1.
- DONE: ap_done=1, ap_idle=1, then IDLE in the same cycle. ap_done stays set until sts_rd is seen with ap_done=1, or until the next accepted cfg_start.
- cfg_start while ap_idle=0 is ignored. sts_rd and cfg_start in the same cycle: start wins, and ap_done clears.
- tap_busy=1 in CLEAR through DRAIN. While busy, tap_EN and tap_A belong to the engine.
- tlast_err:
  - Set if ss_tlast=1 on an accepted sample with cnt!=len-1.
  - Set if ss_tlast=0 on the sample with cnt==len-1.
  - Cleared only by accepted start or reset. The length counter always governs termination.
- wptr wrap: 10 -> 0. Data index (wptr-k) uses mod-11 subtract, never 11..15.

Test Plan:
- Reset, read status -> ap_idle=1, ap_done=0, ap_start=0; all stream/BRAM controls 0.
- len=3, start, samples {1,2,3}, taps 0..10 = 1 -> outputs {1,3,6}; sm_tlast only on third; ap_done=1, ap_idle=1 after third handshake; first sts_rd returns done=1, second returns done=0.
- len=0, start -> no ss_tready or sm_tvalid beyond CLEAR; ap_done=1 exactly 12 cycles after the start pulse.
- len=25, impulse at sample 0, taps h[k]=k+1 -> y[0..10]=1..11, y[11..24]=0 (checks wptr wrap and mod-11 addressing); sm_tready held 1 -> sample spacing 14 cycles.
- len=5, sm_tready toggled 0 for 7 cycles on each output -> sm_tvalid and result stable while stalled; no extra ss_tready.
- Mid-run: assert reset during MAC -> all outputs return to reset values immediately; a fresh len=2 run yields correct results (CLEAR zeroes stale data). Also ss_tlast on sample 1 of len=4 -> tlast_err=1, run still completes with 4 outputs.

Source files
------------

// File: rtl/fir_ctrl.sv
// fir_ctrl: block status and per-sample schedule for the 11-tap FIR.
// Drives data/tap BRAM addressing, MAC control and AXIS handshakes.
module fir_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_start,
  input  logic [pDATA_WIDTH-1:0] cfg_len,
  input  logic                   sts_rd,
  output logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic                   data_sel,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic                   tap_busy,
  output logic                   tlast_err
);

  localparam int IW = $clog2(Tape_Num);
  localparam logic [IW-1:0] KLAST = IW'(Tape_Num - 1);
  localparam logic [IW-1:0] NTAP  = IW'(Tape_Num);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_IN,
    S_MAC,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [IW-1:0]          k;
  logic [IW-1:0]          wptr;
  logic [IW-1:0]          rd_idx;
  logic [pDATA_WIDTH-1:0] cnt;
  logic [pDATA_WIDTH-1:0] len;
  logic                   mac_en_q;

  logic st_idle;
  logic st_clear;
  logic st_in;
  logic st_mac;
  logic st_drain;
  logic st_out;
  logic st_done;
  logic start_ok;
  logic last_smp;
  logic k_last;
  logic in_hs;
  logic out_hs;

  function automatic logic [pADDR_WIDTH-1:0] baddr(
    input logic [IW-1:0] idx
  );
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  assign st_idle  = (state == S_IDLE);
  assign st_clear = (state == S_CLEAR);
  assign st_in    = (state == S_IN);
  assign st_mac   = (state == S_MAC);
  assign st_drain = (state == S_DRAIN);
  assign st_out   = (state == S_OUT);
  assign st_done  = (state == S_DONE);

  assign start_ok = cfg_start & ap_idle
                  & (st_idle | st_done);
  assign last_smp = ((cnt + pDATA_WIDTH'(1)) == len);
  assign k_last   = (k == KLAST);
  assign in_hs    = st_in & ss_tvalid;
  assign out_hs   = st_out & sm_tready;

  assign mac_en   = mac_en_q;
  assign tap_busy = st_clear | st_in | st_mac | st_drain;

  // Circular read index: newest sample minus tap, wrapped into 0..10.
  always_comb begin
    rd_idx = '0;
    if (wptr >= k) begin
      rd_idx = wptr - k;
    end else begin
      rd_idx = wptr + (NTAP - k);
    end
  end

  // State register.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start_ok) nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (k_last) begin
          nxt = (len == '0) ? S_DONE : S_IN;
        end
      end
      S_IN: begin
        if (ss_tvalid) nxt = S_MAC;
      end
      S_MAC: begin
        if (k_last) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        nxt = S_OUT;
      end
      S_OUT: begin
        if (sm_tready) begin
          nxt = last_smp ? S_DONE : S_IN;
        end
      end
      S_DONE: begin
        nxt = start_ok ? S_CLEAR : S_IDLE;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  // BRAM, MAC and stream controls decoded from the current state.
  always_comb begin
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
    data_WE   = 4'h0;
    data_EN   = 1'b0;
    data_A    = '0;
    tap_EN    = 1'b0;
    tap_A     = '0;
    data_sel  = 1'b0;
    mac_clr   = 1'b0;
    unique case (1'b1)
      st_clear: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = baddr(k);
      end
      st_in: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN  = 1'b1;
          data_WE  = 4'hF;
          data_sel = 1'b1;
          data_A   = baddr(wptr);
          mac_clr  = 1'b1;
        end
      end
      st_mac: begin
        tap_EN  = 1'b1;
        tap_A   = baddr(k);
        data_EN = 1'b1;
        data_A  = baddr(rd_idx);
      end
      st_out: begin
        sm_tvalid = 1'b1;
        sm_tlast  = last_smp;
      end
      default: begin
      end
    endcase
  end

  // Tap/clear step counter, write pointer and sample count.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      k    <= '0;
      wptr <= '0;
      cnt  <= '0;
      len  <= '0;
    end else begin
      if ((st_clear | st_mac) & ~k_last) begin
        k <= k + IW'(1);
      end else begin
        k <= '0;
      end
      if (start_ok) begin
        len  <= cfg_len;
        cnt  <= '0;
        wptr <= '0;
      end else if (out_hs) begin
        cnt  <= cnt + pDATA_WIDTH'(1);
        wptr <= (wptr == KLAST) ? '0 : wptr + IW'(1);
      end
    end
  end

  // Data arrives one cycle after its address, so accumulate one late.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      mac_en_q <= 1'b0;
    end else begin
      mac_en_q <= st_mac;
    end
  end

  // Block status: start pulse, sticky done, idle.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ap_start <= 1'b0;
      ap_done  <= 1'b0;
      ap_idle  <= 1'b1;
    end else if (start_ok) begin
      ap_start <= 1'b1;
      ap_done  <= 1'b0;
      ap_idle  <= 1'b0;
    end else begin
      ap_start <= 1'b0;
      if ((nxt == S_DONE) && !st_done) begin
        ap_done <= 1'b1;
        ap_idle <= 1'b1;
      end else if (sts_rd && ap_done) begin
        ap_done <= 1'b0;
      end
    end
  end

  // Sticky flag when ss_tlast disagrees with the programmed length.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      tlast_err <= 1'b0;
    end else if (start_ok) begin
      tlast_err <= 1'b0;
    end else if (in_hs && (ss_tlast != last_smp)) begin
      tlast_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: drives fir_ctrl with behavioural BRAMs and a MAC,
// comparing stream results against a direct FIR convolution.
module tb_fir_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_len = '0;
  logic        sts_rd = 1'b0;
  logic        ap_start, ap_done, ap_idle;
  logic        ss_tvalid = 1'b0;
  logic        ss_tlast = 1'b0;
  logic        ss_tready;
  logic        sm_tready = 1'b0;
  logic        sm_tvalid, sm_tlast;
  logic [3:0]  data_WE;
  logic        data_EN;
  logic [11:0] data_A;
  logic        tap_EN;
  logic [11:0] tap_A;
  logic        data_sel, mac_clr, mac_en;
  logic        tap_busy, tlast_err;
  logic [31:0] ss_tdata = '0;

  fir_ctrl #(
    .pADDR_WIDTH(12),
    .pDATA_WIDTH(32),
    .Tape_Num(11)
  ) dut (
    .axis_clk(axis_clk),
    .axis_rst_n(axis_rst_n),
    .cfg_start(cfg_start),
    .cfg_len(cfg_len),
    .sts_rd(sts_rd),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .ap_idle(ap_idle),
    .ss_tvalid(ss_tvalid),
    .ss_tlast(ss_tlast),
    .ss_tready(ss_tready),
    .sm_tready(sm_tready),
    .sm_tvalid(sm_tvalid),
    .sm_tlast(sm_tlast),
    .data_WE(data_WE),
    .data_EN(data_EN),
    .data_A(data_A),
    .tap_EN(tap_EN),
    .tap_A(tap_A),
    .data_sel(data_sel),
    .mac_clr(mac_clr),
    .mac_en(mac_en),
    .tap_busy(tap_busy),
    .tlast_err(tlast_err)
  );

  always #5 axis_clk = ~axis_clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] tmem [11];
  logic [31:0] dmem [16] = '{default: 32'h0000_DEAD};
  logic [31:0] tap_Do = '0;
  logic [31:0] data_Do = '0;
  longint      acc = 0;
  int          addr_bad = 0;
  int          bad0 = 0;

  int          xs [$];
  longint      ys [$];
  logic        lasts [$];
  int          hs [$];
  int          viol, rdy_seen, smv_seen;

  typedef struct packed {
    logic [7:0]       len;
    logic [1:0]       tk;
    logic [3:0][15:0] x;
    logic [3:0][15:0] y;
  } vec_t;

  vec_t tbl [4];

  // BRAMs with 1-cycle read latency plus the accumulator.
  always @(posedge axis_clk) begin
    if (data_EN) begin
      if (data_A[11:2] > 10 || data_A[1:0] != 0 ||
          (data_WE != 4'h0 && data_WE != 4'hF)) begin
        addr_bad <= addr_bad + 1;
      end else begin
        if (data_WE == 4'hF)
          dmem[data_A[5:2]] <= data_sel ? ss_tdata : 32'd0;
        data_Do <= dmem[data_A[5:2]];
      end
    end
    if (tap_EN) begin
      if (tap_A[11:2] > 10 || tap_A[1:0] != 0)
        addr_bad <= addr_bad + 1;
      else
        tap_Do <= tmem[tap_A[5:2]];
    end
    if (mac_clr)
      acc <= 0;
    else if (mac_en)
      acc <= acc + longint'(tap_Do) * longint'(data_Do);
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint ref_y(input int n);
    longint s = 0;
    for (int t = 0; t < 11; t++)
      if (n - t >= 0)
        s += longint'(tmem[t]) * longint'(xs[n-t]);
    return s;
  endfunction

  task automatic set_taps(input int kind);
    for (int t = 0; t < 11; t++) begin
      case (kind)
        0: tmem[t] = 32'd1;
        1: tmem[t] = 32'(t + 1);
        default: tmem[t] = $urandom_range(0, 500);
      endcase
    end
  endtask

  task automatic rand_xs(input int len);
    xs.delete();
    for (int i = 0; i < len; i++)
      xs.push_back(int'($urandom_range(0, 1000)));
  endtask

  task automatic start_run(input int len, input logic with_rd);
    @(negedge axis_clk);
    cfg_len = 32'(len);
    cfg_start = 1'b1;
    sts_rd = with_rd;
    @(negedge axis_clk);
    cfg_start = 1'b0;
    sts_rd = 1'b0;
    chk("ap_start_pulse", ap_start, 1);
    chk("ap_done_cleared", ap_done, 0);
  endtask

  task automatic do_run(input int len, input int stall,
                        input int bad, input logic with_rd,
                        output int done_cyc);
    int i_in, cyc, st;
    logic held, hl;
    longint hv;
    ys.delete();
    lasts.delete();
    hs.delete();
    viol = 0;
    rdy_seen = 0;
    smv_seen = 0;
    bad0 = addr_bad;
    i_in = 0;
    st = 0;
    held = 0;
    hl = 0;
    hv = 0;
    start_run(len, with_rd);
    cyc = 1;
    while (!ap_done && cyc < 40 * len + 100) begin
      cfg_start = (cyc == 5);
      cfg_len = (cyc == 5) ? 32'(len + 3) : 32'(len);
      if (cyc == 2) begin
        chk("ap_start_low", ap_start, 0);
        chk("ap_idle_low", ap_idle, 0);
      end
      ss_tvalid = (i_in < len);
      ss_tdata = ss_tvalid ? 32'(xs[i_in]) : 32'd0;
      ss_tlast = ss_tvalid &&
                 ((i_in == len - 1) != (i_in == bad));
      sm_tready = !(sm_tvalid && st < stall);
      if (ss_tready) rdy_seen++;
      if (held && !sm_tvalid) viol++;
      if (sm_tvalid) begin
        smv_seen++;
        if (ss_tready) viol++;
        if (held && (acc != hv || sm_tlast != hl)) viol++;
        held = 1;
        hv = acc;
        hl = sm_tlast;
      end
      #1;
      if (ss_tvalid && ss_tready) i_in++;
      if (sm_tvalid && sm_tready) begin
        ys.push_back(acc);
        lasts.push_back(sm_tlast);
        hs.push_back(cyc);
        st = 0;
        held = 0;
      end else if (sm_tvalid) begin
        st++;
      end
      @(negedge axis_clk);
      cyc++;
    end
    cfg_start = 1'b0;
    ss_tvalid = 1'b0;
    ss_tlast = 1'b0;
    sm_tready = 1'b1;
    chk("run_reaches_done", ap_done, 1);
    done_cyc = cyc;
  endtask

  task automatic check_ref(input string nm, input int len);
    chk({nm, "_count"}, ys.size(), len);
    for (int i = 0; i < len && i < ys.size(); i++) begin
      chk({nm, "_y"}, ys[i], ref_y(i));
      chk({nm, "_last"}, lasts[i], (i == len - 1));
    end
    chk({nm, "_stream_viol"}, viol, 0);
    chk({nm, "_tready_cycles"}, rdy_seen, len);
    chk({nm, "_addr"}, addr_bad - bad0, 0);
  endtask

  task automatic sts_read(output logic d);
    @(negedge axis_clk);
    sts_rd = 1'b1;
    d = ap_done;
    @(negedge axis_clk);
    sts_rd = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ap_idle"}, ap_idle, 1);
    chk({nm, "_ap_done"}, ap_done, 0);
    chk({nm, "_ap_start"}, ap_start, 0);
    chk({nm, "_ss_tready"}, ss_tready, 0);
    chk({nm, "_sm_tvalid"}, sm_tvalid, 0);
    chk({nm, "_sm_tlast"}, sm_tlast, 0);
    chk({nm, "_data_EN"}, data_EN, 0);
    chk({nm, "_data_WE"}, data_WE, 0);
    chk({nm, "_data_A"}, data_A, 0);
    chk({nm, "_tap_EN"}, tap_EN, 0);
    chk({nm, "_tap_A"}, tap_A, 0);
    chk({nm, "_data_sel"}, data_sel, 0);
    chk({nm, "_mac_clr"}, mac_clr, 0);
    chk({nm, "_mac_en"}, mac_en, 0);
    chk({nm, "_tap_busy"}, tap_busy, 0);
    chk({nm, "_tlast_err"}, tlast_err, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, n, len;
    logic d;

    tbl[0] = '{len: 8'd3, tk: 2'd0,
               x: {16'd0, 16'd3, 16'd2, 16'd1},
               y: {16'd0, 16'd6, 16'd3, 16'd1}};
    tbl[1] = '{len: 8'd2, tk: 2'd1,
               x: {16'd0, 16'd0, 16'd7, 16'd5},
               y: {16'd0, 16'd0, 16'd17, 16'd5}};
    tbl[2] = '{len: 8'd4, tk: 2'd1,
               x: {16'd2, 16'd0, 16'd0, 16'd1},
               y: {16'd6, 16'd3, 16'd2, 16'd1}};
    tbl[3] = '{len: 8'd1, tk: 2'd0,
               x: {16'd0, 16'd0, 16'd0, 16'd9},
               y: {16'd0, 16'd0, 16'd0, 16'd9}};

    repeat (3) @(negedge axis_clk);
    chk_reset("rst_held");
    axis_rst_n = 1'b1;
    sm_tready = 1'b1;
    @(negedge axis_clk);
    chk_reset("rst_rel");

    for (int v = 0; v < 4; v++) begin
      len = int'(tbl[v].len);
      set_taps(int'(tbl[v].tk));
      xs.delete();
      for (int i = 0; i < len; i++)
        xs.push_back(int'(tbl[v].x[i]));
      do_run(len, 0, -1, 1'b0, dc);
      chk("vec_count", ys.size(), len);
      for (int i = 0; i < len; i++) begin
        chk("vec_y", (i < ys.size()) ? ys[i] : -1,
            longint'(tbl[v].y[i]));
        chk("vec_last", (i < lasts.size()) ? lasts[i] : 1'bx,
            (i == len - 1));
      end
      chk("vec_done", ap_done, 1);
      chk("vec_idle", ap_idle, 1);
      chk("vec_tlast_err", tlast_err, 0);
      sts_read(d);
      chk("sts_rd_first", d, 1);
      sts_read(d);
      chk("sts_rd_second", d, 0);
    end

    xs.delete();
    do_run(0, 0, -1, 1'b0, dc);
    chk("len0_done_cycle", dc, 12);
    chk("len0_tready", rdy_seen, 0);
    chk("len0_tvalid", smv_seen, 0);
    do_run(0, 0, -1, 1'b1, dc);
    chk("len0_rd_start_done_cycle", dc, 12);

    set_taps(1);
    xs.delete();
    for (int i = 0; i < 25; i++) xs.push_back(i == 0 ? 1 : 0);
    do_run(25, 0, -1, 1'b0, dc);
    check_ref("impulse", 25);
    for (int i = 0; i < 25 && i < ys.size(); i++)
      chk("impulse_shape", ys[i], (i < 11) ? i + 1 : 0);
    for (int i = 1; i < hs.size(); i++)
      chk("impulse_spacing", hs[i] - hs[i-1], 14);

    set_taps(2);
    rand_xs(5);
    do_run(5, 7, -1, 1'b0, dc);
    check_ref("stall", 5);

    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(1, 14));
      set_taps(2);
      rand_xs(len);
      do_run(len, int'($urandom_range(0, 3)), -1, 1'b0, dc);
      check_ref("rand", len);
    end

    set_taps(2);
    rand_xs(6);
    start_run(6, 1'b0);
    n = 0;
    while (!tap_EN && n < 100) begin
      ss_tvalid = 1'b1;
      ss_tdata = 32'(xs[0]);
      @(negedge axis_clk);
      n++;
    end
    chk("abort_reach_mac", tap_EN, 1);
    axis_rst_n = 1'b0;
    ss_tvalid = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    rand_xs(2);
    do_run(2, 0, -1, 1'b0, dc);
    check_ref("after_abort", 2);

    rand_xs(4);
    do_run(4, 0, 1, 1'b0, dc);
    check_ref("tlast_early", 4);
    chk("tlast_early_err", tlast_err, 1);
    rand_xs(2);
    do_run(2, 0, 1, 1'b0, dc);
    check_ref("tlast_missing", 2);
    chk("tlast_missing_err", tlast_err, 1);
    rand_xs(1);
    do_run(1, 0, -1, 1'b0, dc);
    check_ref("tlast_clean", 1);
    chk("tlast_clean_err", tlast_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
